// File: rtl/snn_layer_epoch_ctrl.sv
// snn_layer_epoch_ctrl: preload/stream/train sequencer with per-node ones counters.
// Define SNN_EPOCH_BIPOLAR_EN to report 2*ones-L instead of the raw ones count.
module snn_layer_epoch_ctrl #(
  parameter int NODES = 5,
  parameter int LW    = 10,
  parameter int PRE   = 2
) (
  input  logic                     CLK,
  input  logic                     INIT_n,
  input  logic                     start,
  input  logic [LW-1:0]            stream_len,
  input  logic                     train_en,
  input  logic [3:0]               train_cycles,
  input  logic [NODES-1:0]         a_out,
  input  logic                     res_ready,
  output logic                     layer_init,
  output logic                     training_flag,
  output logic                     busy,
  output logic                     res_valid,
  output logic [NODES*(LW+1)-1:0]  res_count
);

  localparam int CW = (LW > 4) ? LW : 4;
  localparam int FW = LW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_RUN,
    S_TRAIN,
    S_HOLD
  } state_e;

  state_e                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [LW-1:0]                len_q, len_d;
  logic                         ten_q, ten_d;
  logic [3:0]                   tcy_q, tcy_d;
  logic [NODES-1:0][LW-1:0]     ones_q, ones_d;
  logic [NODES*FW-1:0]          res_q, res_d;
  logic                         train_go;
  logic                         hold_entry;

  assign train_go = ten_q && (tcy_q != 4'd0);

  // Phase sequencing: each state loads the counter with its length minus one.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ten_d   = ten_q;
    tcy_d   = tcy_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PRELOAD;
          cnt_d   = CW'(PRE - 1);
          len_d   = stream_len;
          ten_d   = train_en;
          tcy_d   = train_cycles;
        end
      end
      S_PRELOAD: begin
        if (cnt_q == '0) begin
          if (len_q != '0) begin
            state_d = S_RUN;
            cnt_d   = CW'(len_q) - CW'(1);
          end else if (train_go) begin
            state_d = S_TRAIN;
            cnt_d   = CW'(tcy_q) - CW'(1);
          end else begin
            state_d = S_HOLD;
            cnt_d   = '0;
          end
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          if (train_go) begin
            state_d = S_TRAIN;
            cnt_d   = CW'(tcy_q) - CW'(1);
          end else begin
            state_d = S_HOLD;
            cnt_d   = '0;
          end
        end
      end
      S_TRAIN: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Ones counters: clear on acceptance, accumulate a_out in every RUN cycle.
  always_comb begin
    ones_d = ones_q;
    for (int i = 0; i < NODES; i++) begin
      if (state_q == S_IDLE && start) begin
        ones_d[i] = '0;
      end else if (state_q == S_RUN) begin
        ones_d[i] = ones_q[i] + LW'(a_out[i]);
      end
    end
  end

  assign hold_entry = (state_d == S_HOLD) && (state_q != S_HOLD);

  // Result capture on HOLD entry, including the final RUN sample.
  always_comb begin
    res_d = res_q;
    if (hold_entry) begin
      for (int i = 0; i < NODES; i++) begin
`ifdef SNN_EPOCH_BIPOLAR_EN
        res_d[i*FW +: FW] = {ones_d[i], 1'b0} - {1'b0, len_q};
`else
        res_d[i*FW +: FW] = {1'b0, ones_d[i]};
`endif
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!INIT_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      ten_q   <= 1'b0;
      tcy_q   <= '0;
      ones_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ten_q   <= ten_d;
      tcy_q   <= tcy_d;
      ones_q  <= ones_d;
      res_q   <= res_d;
    end
  end

  assign layer_init    = (state_q == S_PRELOAD);
  assign training_flag = (state_q == S_TRAIN);
  assign busy          = (state_q != S_IDLE);
  assign res_valid     = (state_q == S_HOLD);
  assign res_count     = res_q;

endmodule

// File: tb/tb_snn_layer_epoch_ctrl.sv
// Directed bench for snn_layer_epoch_ctrl with a result scoreboard.
// Expected counts follow SNN_EPOCH_BIPOLAR_EN when defined.
module tb_snn_layer_epoch_ctrl;

  localparam int NODES = 5;
  localparam int LW    = 8;
  localparam int PRE   = 2;
  localparam int FW    = LW + 1;
  localparam int RW    = NODES * FW;

  logic             CLK = 1'b0;
  logic             INIT_n;
  logic             start;
  logic [LW-1:0]    stream_len;
  logic             train_en;
  logic [3:0]       train_cycles;
  logic [NODES-1:0] a_out;
  logic             res_ready;
  logic             layer_init;
  logic             training_flag;
  logic             busy;
  logic             res_valid;
  logic [RW-1:0]    res_count;

  int vectors     = 0;
  int miscompares = 0;
  logic [RW-1:0] sb_q[$];

  always #5 CLK = ~CLK;

  snn_layer_epoch_ctrl #(.NODES(NODES), .LW(LW), .PRE(PRE)) dut (
    .CLK(CLK),
    .INIT_n(INIT_n),
    .start(start),
    .stream_len(stream_len),
    .train_en(train_en),
    .train_cycles(train_cycles),
    .a_out(a_out),
    .res_ready(res_ready),
    .layer_init(layer_init),
    .training_flag(training_flag),
    .busy(busy),
    .res_valid(res_valid),
    .res_count(res_count)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] fexp(input int ones, input int len);
`ifdef SNN_EPOCH_BIPOLAR_EN
    return FW'(2 * ones - len);
`else
    return FW'(ones);
`endif
  endfunction

  task automatic epoch(input string tag, input int len, input bit ten,
                       input int tcy, input int mode, input int hold_n);
    logic [NODES-1:0] pv[256];
    int               ones[NODES];
    logic [RW-1:0]    exp;
    logic [RW-1:0]    held;
    logic [RW-1:0]    popped;
    int               tp, lat, ni, nt;
    for (int i = 0; i < NODES; i++) ones[i] = 0;
    for (int j = 1; j <= len; j++) begin
      case (mode)
        0:       pv[j] = '1;
        1:       pv[j] = (j % 2 == 0) ? 5'b00101 : 5'b00000;
        default: pv[j] = NODES'($urandom);
      endcase
      for (int i = 0; i < NODES; i++) ones[i] += int'(pv[j][i]);
    end
    exp = '0;
    for (int i = 0; i < NODES; i++) exp[i*FW +: FW] = fexp(ones[i], len);
    sb_q.push_back(exp);
    tp = (ten && tcy != 0) ? tcy : 0;
    stream_len   = LW'(len);
    train_en     = ten;
    train_cycles = 4'(tcy);
    res_ready    = 1'b0;
    start        = 1'b1;
    step();
    start        = 1'b0;
    stream_len   = LW'($urandom);
    train_en     = ~ten;
    train_cycles = 4'($urandom);
    chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
    lat = 0;
    ni  = 0;
    nt  = 0;
    for (int n = 1; n <= 600; n++) begin
      if (res_valid) begin
        lat = n;
        break;
      end
      if (layer_init) ni++;
      if (training_flag) nt++;
      a_out = (n - PRE >= 1 && n - PRE <= len) ? pv[n-PRE] : NODES'($urandom);
      step();
    end
    chk({tag, "_latency"}, 64'(lat), 64'(PRE + len + tp + 1));
    chk({tag, "_init_cycles"}, 64'(ni), 64'(PRE));
    chk({tag, "_train_cycles"}, 64'(nt), 64'(tp));
    held = res_count;
    for (int h = 0; h < hold_n; h++) begin
      start = (h % 2 == 0);
      chk({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
      chk({tag, "_hold_stable"}, 64'(res_count), 64'(held));
      step();
    end
    res_ready = 1'b1;
    start     = 1'b1;
    chk({tag, "_hs_valid"}, 64'(res_valid), 64'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      popped = sb_q.pop_front();
      chk({tag, "_count"}, 64'(res_count), 64'(popped));
    end
    step();
    res_ready = 1'b0;
    start     = 1'b0;
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_valid"}, 64'(res_valid), 64'd0);
  endtask

  initial begin
    INIT_n       = 1'b0;
    start        = 1'b0;
    stream_len   = '0;
    train_en     = 1'b0;
    train_cycles = '0;
    a_out        = '0;
    res_ready    = 1'b0;
    step();
    step();
    chk("rst_init", 64'(layer_init), 64'd0);
    chk("rst_train", 64'(training_flag), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_count", 64'(res_count), 64'd0);
    INIT_n    = 1'b1;
    res_ready = 1'b1;
    step();
    chk("idle_ready_ignored", 64'(busy), 64'd0);

    epoch("ones_all", 10, 1'b0, 0, 0, 0);
    epoch("per_node", 8, 1'b0, 0, 1, 1);
    epoch("train3", 4, 1'b1, 3, 2, 0);
    epoch("zero_bp", 0, 1'b0, 0, 2, 5);
    epoch("zero_train", 0, 1'b1, 2, 2, 2);
    epoch("train_t0", 3, 1'b1, 0, 0, 0);

    stream_len = LW'(10);
    train_en   = 1'b0;
    res_ready  = 1'b1;
    a_out      = '1;
    start      = 1'b1;
    step();
    start = 1'b0;
    repeat (PRE + 3) step();
    chk("mid_busy_pre", 64'(busy), 64'd1);
    INIT_n = 1'b0;
    step();
    INIT_n = 1'b1;
    chk("mid_rst_init", 64'(layer_init), 64'd0);
    chk("mid_rst_train", 64'(training_flag), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_count", 64'(res_count), 64'd0);
    step();
    chk("mid_rst_idle", 64'(busy), 64'd0);

    epoch("after_rst", 6, 1'b1, 2, 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snn_layer_epoch_ctrl.md
# snn_layer_epoch_ctrl

Epoch sequencer for one fully connected stochastic layer. It drives the layer's INIT and CLK_TRAINING_flag inputs through a fixed preload, stream and training sequence. During the stream phase it counts the ones on each node's `a_out` bitstream and hands the per-node counts to the downstream consumer through a valid/ready handshake. One instance sits beside each fully connected layer block.

## Interface
Parameters:
- `NODES`, 5, number of layer nodes (width of `a_out`).
- `LW`, 10, width of the stream-length and per-node count fields.
- `PRE`, 2, preload cycles; must be ≥ 1.

Ports:
- `CLK`  in  1  clock; all logic on the rising edge.
- `INIT_n`  in  1  synchronous reset, active-low.
- `start`  in  1  epoch request; sampled only in IDLE.
- `stream_len`  in  LW  bitstream length L; latched at start acceptance.
- `train_en`  in  1  enables the training phase; latched at start acceptance.
- `train_cycles`  in  4  training-phase length T; latched at start acceptance.
- `a_out`  in  NODES  node output bits from the layer.
- `res_ready`  in  1  consumer accepts the result.
- `layer_init`  out  1  drives the layer's INIT input.
- `training_flag`  out  1  drives the layer's CLK_TRAINING_flag input.
- `busy`  out  1  high in every state except IDLE.
- `res_valid`  out  1  result available.
- `res_count`  out  NODES*(LW+1)  per-node count; node i occupies bits [i*(LW+1) +: LW+1].

## Operation
- States:
  - IDLE: `start` moves the FSM to PRELOAD and latches L, `train_en` and T.
  - PRELOAD: lasts PRE cycles, then goes to RUN, or to TRAIN/HOLD when L = 0.
  - RUN: lasts L cycles, then goes to TRAIN if `train_en` and T ≠ 0, otherwise to HOLD.
  - TRAIN: lasts T cycles, then goes to HOLD.
  - HOLD: returns to IDLE on `res_valid & res_ready`.
- Outputs are Moore, decoded from registered state:
  - `layer_init` = 1 only in PRELOAD.
  - `training_flag` = 1 only in TRAIN.
  - `res_valid` = 1 only in HOLD.
- One phase counter, width max(LW,4), loads at each state entry and counts down. It never wraps.
- Per-node ones counters clear on entry to PRELOAD. During RUN, node i's counter increments at each RUN-cycle edge where `a_out[i]` = 1. A counter can reach at most L, so it never overflows.
- `res_count` is registered and updated on the edge that enters HOLD. It stays stable until the next epoch's HOLD entry.
- L = 0: RUN is skipped and all counts are 0 (signed mode: 0).
- `start` outside IDLE is ignored; no queuing.
- Input changes to `stream_len`, `train_en` or `train_cycles` after acceptance have no effect on the current epoch.
- Reset (`INIT_n` = 0), at any point including mid-epoch:
  - state goes to IDLE;
  - all counters clear;
  - `layer_init`, `training_flag`, `busy`, `res_valid` = 0;
  - `res_count` = 0.

## Timing
- The timeline counts from the edge at which `start` is accepted as edge k:
  - PRELOAD covers cycles k+1 … k+PRE.
  - RUN covers cycles k+PRE+1 … k+PRE+L.
  - TRAIN covers the next T cycles.
  - `res_valid` rises in cycle k+PRE+L+T'+1, where T' = T if training is enabled and T ≠ 0, else T' = 0.
- `a_out` is sampled on the closing edge of each RUN cycle, giving exactly L samples per node.
- Handshake:
  - HOLD exits on the edge where `res_valid & res_ready` is high.
  - The FSM is back in IDLE the following cycle, so the earliest next acceptance is one cycle after the handshake.
  - `res_ready` while not valid is ignored.
- `busy` rises the cycle after acceptance and falls the cycle after the handshake.

## Configuration
- `SNN_EPOCH_BIPOLAR_EN` defined: each count field reports the bipolar value 2·ones − L, two's complement, LW+1 bits. This matches bipolar (BGPOLAR) node encoding.
- Undefined: each field reports the unsigned ones count, zero-extended to LW+1 bits (MSB = 0).
- The FSM and timing are identical in both builds.

## Test plan
All scenarios use NODES=5, LW=8, PRE=2.
- Ones-count check: reset, L=10, `train_en`=0, `a_out`=5'b11111 throughout → `layer_init` high for 2 cycles; `res_valid` in cycle k+13; all counts 10. Bipolar build: all counts +10.
- Per-node counting: L=8, `a_out`=5'b00101 on even RUN cycles, 0 otherwise → counts {0,0,4,0,4}. Bipolar build: {−8,−8,0,−8,0}.
- Training phase: `train_en`=1, T=3, L=4 → `training_flag` high for exactly 3 cycles after RUN; `res_valid` in cycle k+10.
- Zero length and back-pressure: L=0, `res_ready` held low for 5 cycles → counts 0; `res_valid` and `res_count` held stable throughout; `start` pulses during HOLD ignored; IDLE the cycle after `res_ready`.
- Reset mid-epoch: `INIT_n` low during RUN → next cycle all outputs 0 and state IDLE; a fresh start then completes normally.
